// File: rtl/sram_ecc_pkg.sv
// Shared constants, FSM state type and the SECDED(39,32) encoder.
// Codeword layout: [31:0] data, [37:32] Hamming check bits, [38] overall parity.
package sram_ecc_pkg;

  localparam int DATA_W = 32;
  localparam int ECC_W  = 7;
  localparam int BITS   = DATA_W + ECC_W;
  localparam int ADDR_W = 11;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RMW_RD,
    RMW_WR
  } state_t;

  // Row k selects the data bits whose Hamming position (3,5,6,7,9,...,38) has bit k set.
  localparam logic [5:0][DATA_W-1:0] H_MAT = {
    32'hFC000000,
    32'h03FFF800,
    32'h03FC07F0,
    32'hE3C3C78E,
    32'h9B33366D,
    32'h56AAAD5B
  };

  // Column j of H: the syndrome produced by a flip of data bit j.
  function automatic logic [5:0] h_col(input int j);
    logic [5:0] col;
    col = '0;
    for (int k = 0; k < 6; k++) begin
      col[k] = H_MAT[k][j];
    end
    return col;
  endfunction

  function automatic logic [ECC_W-1:0] enc(input logic [DATA_W-1:0] d);
    logic [ECC_W-1:0] c;
    c = '0;
    for (int k = 0; k < 6; k++) begin
      c[k] = ^(d & H_MAT[k]);
    end
    c[6] = ^{d, c[5:0]};
    return c;
  endfunction

endpackage

// File: rtl/secded_39_32_dec.sv
// Combinational SECDED decoder: corrects any single flipped bit, flags double flips.
// On a double error the raw data bits pass through unchanged.
module secded_39_32_dec
  import sram_ecc_pkg::*;
(
  input  logic [BITS-1:0]   cw_i,
  output logic [DATA_W-1:0] data_o,
  output logic              err_corr_o,
  output logic              err_uncorr_o
);

  logic [5:0]        syn;
  logic              par;
  logic [DATA_W-1:0] flip;

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_syn
      assign syn[gi] = (^(cw_i[DATA_W-1:0] & H_MAT[gi])) ^ cw_i[DATA_W+gi];
    end
    // Syndromes that point at a check bit match no data column, so data is left alone.
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_flip
      assign flip[gi] = par && (syn == h_col(gi));
    end
  endgenerate

  assign par          = ^cw_i;
  assign err_corr_o   = par;
  assign err_uncorr_o = !par && (syn != 6'd0);
  assign data_o       = cw_i[DATA_W-1:0] ^ flip;

endmodule

// File: rtl/sram_ecc_ctrl.sv
// SECDED front-end for a 2048x39 single-port SRAM: encoded writes, corrected reads,
// and read-modify-write for byte-masked writes. RAM ports are driven combinationally.
module sram_ecc_ctrl
  import sram_ecc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err_corr,
  output logic              rsp_err_uncorr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [BITS-1:0]   ram_wd,
  output logic [BITS-1:0]   ram_wmask,
  input  logic [BITS-1:0]   ram_rd
);

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        be_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_corr_q;
  logic              rsp_err_uncorr_q;
  logic [CNT_W-1:0]  corr_cnt_q;

  logic [DATA_W-1:0] dec_data;
  logic              dec_corr;
  logic              dec_uncorr;
  logic [DATA_W-1:0] merged_d;
  logic              accept;
  logic              be_full;
  logic              be_none;

  secded_39_32_dec u_dec (
    .cw_i        (ram_rd),
    .data_o      (dec_data),
    .err_corr_o  (dec_corr),
    .err_uncorr_o(dec_uncorr)
  );

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      assign merged_d[8*gi +: 8] = be_q[gi] ? wdata_q[8*gi +: 8] : dec_data[8*gi +: 8];
    end
  endgenerate

  assign accept  = (state_q == IDLE) && req_valid;
  assign be_full = (req_be == 4'hF);
  assign be_none = (req_be == 4'h0);

  assign req_ready      = rst_n && (state_q == IDLE);
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_err_corr   = rsp_err_corr_q;
  assign rsp_err_uncorr = rsp_err_uncorr_q;
  assign corr_cnt       = corr_cnt_q;

  // Gated by rst_n so the macro sees no access while reset is held, whatever the request.
  always_comb begin
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wd    = '0;
    ram_wmask = '0;
    if (rst_n) begin
      if (accept) begin
        if (!req_we) begin
          ram_ce   = 1'b1;
          ram_addr = req_addr;
        end else if (be_full) begin
          ram_ce    = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = req_addr;
          ram_wd    = {enc(req_wdata), req_wdata};
          ram_wmask = '1;
        end else if (!be_none) begin
          ram_ce   = 1'b1;
          ram_addr = req_addr;
        end
      end else if (state_q == RMW_WR) begin
        ram_ce    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = addr_q;
        ram_wd    = {enc(wdata_q), wdata_q};
        ram_wmask = '1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      addr_q           <= '0;
      wdata_q          <= '0;
      be_q             <= '0;
      rsp_valid_q      <= 1'b0;
      rsp_rdata_q      <= '0;
      rsp_err_corr_q   <= 1'b0;
      rsp_err_uncorr_q <= 1'b0;
      corr_cnt_q       <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            if (!req_we) begin
              state_q <= RD_WAIT;
            end else if (!be_full && !be_none) begin
              addr_q  <= req_addr;
              wdata_q <= req_wdata;
              be_q    <= req_be;
              state_q <= RMW_RD;
            end
          end
        end
        RD_WAIT: begin
          rsp_valid_q      <= 1'b1;
          rsp_rdata_q      <= dec_data;
          rsp_err_corr_q   <= dec_corr;
          rsp_err_uncorr_q <= dec_uncorr;
          if (dec_corr && (corr_cnt_q != '1)) begin
            corr_cnt_q <= corr_cnt_q + CNT_W'(1);
          end
          state_q <= IDLE;
        end
        RMW_RD: begin
          if (dec_uncorr) begin
            // Abandon the merge: rewriting would bake the corrupted bytes into a clean codeword.
            rsp_valid_q      <= 1'b1;
            rsp_rdata_q      <= '0;
            rsp_err_corr_q   <= 1'b0;
            rsp_err_uncorr_q <= 1'b1;
            state_q          <= IDLE;
          end else begin
            wdata_q <= merged_d;
            if (dec_corr && (corr_cnt_q != '1)) begin
              corr_cnt_q <= corr_cnt_q + CNT_W'(1);
            end
            state_q <= RMW_WR;
          end
        end
        RMW_WR: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ecc_ctrl.sv
// Bench for sram_ecc_ctrl: behavioural SRAM with read-data bit-flip injection,
// a word-level reference model and a per-cycle compare of responses and RAM writes.
`timescale 1ns/1ps
module tb_sram_ecc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [10:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err_corr;
  logic        rsp_err_uncorr;
  logic [15:0] corr_cnt;
  logic        ram_ce;
  logic        ram_we;
  logic [10:0] ram_addr;
  logic [38:0] ram_wd;
  logic [38:0] ram_wmask;
  logic [38:0] ram_rd;
  logic [38:0] ram_rd_raw = '0;
  logic [38:0] flip_mask = '0;
  logic [38:0] mem [2048];

  // Second instance with a 2-bit counter so saturation is reached in a few reads.
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        s_rsp_valid;
  logic [31:0] s_rdata;
  logic        s_corr;
  logic        s_uncorr;
  logic [1:0]  s_cnt;
  logic        s_ram_ce;
  logic        s_ram_we;
  logic [10:0] s_ram_addr;
  logic [38:0] s_ram_wd;
  logic [38:0] s_ram_wmask;
  logic [38:0] s_ram_rd;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        corr;
    logic        uncorr;
    logic [15:0] cnt;
    int          cyc;
  } rsp_t;
  typedef struct {
    logic [10:0] addr;
    logic [38:0] wd;
  } wr_t;
  rsp_t rsp_q[$];
  wr_t  wr_q[$];

  logic [31:0] ref_mem [2048];
  int          ref_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Independent encoder: place data bits at non-power-of-two positions 1..38.
  function automatic logic [38:0] model_enc(input logic [31:0] d);
    logic [6:0] c;
    int j;
    c = '0;
    j = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        for (int k = 0; k < 6; k++) begin
          if (p[k]) c[k] = c[k] ^ d[j];
        end
        j++;
      end
    end
    c[6] = ^{d, c[5:0]};
    return {c, d};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  sram_ecc_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_be        (req_be),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_err_corr  (rsp_err_corr),
    .rsp_err_uncorr(rsp_err_uncorr),
    .corr_cnt      (corr_cnt),
    .ram_ce        (ram_ce),
    .ram_we        (ram_we),
    .ram_addr      (ram_addr),
    .ram_wd        (ram_wd),
    .ram_wmask     (ram_wmask),
    .ram_rd        (ram_rd)
  );

  sram_ecc_ctrl #(.CNT_W(2)) dut_sat (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (s_valid),
    .req_ready     (s_ready),
    .req_we        (1'b0),
    .req_addr      (11'd0),
    .req_wdata     (32'd0),
    .req_be        (4'd0),
    .rsp_valid     (s_rsp_valid),
    .rsp_rdata     (s_rdata),
    .rsp_err_corr  (s_corr),
    .rsp_err_uncorr(s_uncorr),
    .corr_cnt      (s_cnt),
    .ram_ce        (s_ram_ce),
    .ram_we        (s_ram_we),
    .ram_addr      (s_ram_addr),
    .ram_wd        (s_ram_wd),
    .ram_wmask     (s_ram_wmask),
    .ram_rd        (s_ram_rd)
  );

  assign s_ram_rd = model_enc(32'hCAFEF00D) ^ 39'h200;

  // SRAM macro: registered read, bit-masked write.
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we) mem[ram_addr] <= (mem[ram_addr] & ~ram_wmask) | (ram_wd & ram_wmask);
      else        ram_rd_raw <= mem[ram_addr];
    end
  end
  assign ram_rd = ram_rd_raw ^ flip_mask;

  // Compare process: every response and every RAM write against the model's queues.
  always @(negedge clk) begin
    rsp_t e;
    wr_t  w;
    if (rst_n) begin
      if (rsp_valid) begin
        chk("rsp_expected", 64'(rsp_q.size() > 0), 64'd1);
        if (rsp_q.size() > 0) begin
          e = rsp_q.pop_front();
          chk("rsp_latency", 64'(cyc), 64'(e.cyc));
          chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          chk("rsp_err_corr", 64'(rsp_err_corr), 64'(e.corr));
          chk("rsp_err_uncorr", 64'(rsp_err_uncorr), 64'(e.uncorr));
          chk("corr_cnt", 64'(corr_cnt), 64'(e.cnt));
        end
      end
      if (ram_ce && ram_we) begin
        chk("wr_expected", 64'(wr_q.size() > 0), 64'd1);
        if (wr_q.size() > 0) begin
          w = wr_q.pop_front();
          chk("wr_addr", 64'(ram_addr), 64'(w.addr));
          chk("wr_codeword", 64'(ram_wd), 64'(w.wd));
          chk("wr_mask", 64'(ram_wmask), {25'd0, {39{1'b1}}});
        end
      end
    end
  end

  task automatic do_req(input logic we, input logic [10:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input logic [38:0] flip);
    rsp_t        e;
    wr_t         w;
    logic        has_rsp;
    logic        ok;
    int          nf;
    logic [31:0] m;
    has_rsp = 1'b0;
    ok      = 1'b0;
    nf      = $countones(flip);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
    flip_mask = flip;
    if (!we) begin
      has_rsp = 1'b1;
      if (nf == 1 && ref_cnt < 65535) ref_cnt++;
      e.rdata  = (nf >= 2) ? (ref_mem[a] ^ flip[31:0]) : ref_mem[a];
      e.corr   = (nf == 1);
      e.uncorr = (nf >= 2);
      e.cnt    = 16'(ref_cnt);
    end else if (be == 4'hF) begin
      ref_mem[a] = wd;
      w.addr = a; w.wd = model_enc(wd); wr_q.push_back(w);
    end else if (be != 4'h0) begin
      if (nf >= 2) begin
        has_rsp = 1'b1;
        e.rdata = '0; e.corr = 1'b0; e.uncorr = 1'b1; e.cnt = 16'(ref_cnt);
      end else begin
        m = ref_mem[a];
        for (int b = 0; b < 4; b++) if (be[b]) m[8*b +: 8] = wd[8*b +: 8];
        ref_mem[a] = m;
        if (nf == 1 && ref_cnt < 65535) ref_cnt++;
        w.addr = a; w.wd = model_enc(m); wr_q.push_back(w);
      end
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    chk("req_accept", 64'(ok), 64'd1);
    if (!ok) begin
      req_valid = 1'b0; flip_mask = '0;
      return;
    end
    if (we && be == 4'h0) chk("be0_no_access", 64'(ram_ce), 64'd0);
    if (has_rsp) begin
      e.cyc = cyc + 2;
      rsp_q.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!we) begin
      @(negedge clk);
      chk("ready_low_rd_wait", 64'(req_ready), 64'd0);
    end
    @(posedge clk); #1;
    flip_mask = '0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    for (int i = 0; i < 2048; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ram_ce", 64'(ram_ce), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("reset_err_flags", 64'({rsp_err_corr, rsp_err_uncorr}), 64'd0);
    chk("reset_corr_cnt", 64'(corr_cnt), 64'd0);
    chk("reset_req_ready", 64'(req_ready), 64'd1);

    chk("pin_enc_bit0", 64'(model_enc(32'h00000001)), 64'h43_0000_0001);
    chk("pin_enc_bit31", 64'(model_enc(32'h80000000)), 64'h26_8000_0000);

    do_req(1'b1, 11'h005, 32'hDEADBEEF, 4'hF, '0);
    do_req(1'b0, 11'h005, '0, 4'h0, '0);

    do_req(1'b1, 11'h010, 32'h12345678, 4'hF, '0);
    do_req(1'b0, 11'h010, '0, 4'h0, 39'h80);
    do_req(1'b0, 11'h010, '0, 4'h0, 39'h40_0000_0000);
    do_req(1'b0, 11'h010, '0, 4'h0, 39'h10_0008);
    do_req(1'b0, 11'h010, '0, 4'h0, '0);

    do_req(1'b1, 11'h7FF, 32'hAABBCCDD, 4'hF, '0);
    do_req(1'b1, 11'h7FF, 32'h11223344, 4'b0101, '0);
    chk("pin_rmw_merge", 64'(ref_mem[11'h7FF]), 64'hAA22CC44);
    do_req(1'b0, 11'h7FF, '0, 4'h0, '0);
    do_req(1'b1, 11'h7FF, 32'h55667788, 4'b1010, 39'h2_0000_0001);
    do_req(1'b0, 11'h7FF, '0, 4'h0, '0);
    do_req(1'b1, 11'h7FF, 32'h0000EE00, 4'b0010, 39'h1000);
    do_req(1'b0, 11'h7FF, '0, 4'h0, '0);
    do_req(1'b1, 11'h7FF, 32'h00000000, 4'h0, '0);
    do_req(1'b0, 11'h7FF, '0, 4'h0, '0);

    do_req(1'b1, 11'h020, 32'h00000001, 4'hF, '0);
    do_req(1'b1, 11'h021, 32'h80000000, 4'hF, '0);
    do_req(1'b0, 11'h020, '0, 4'h0, 39'h1);
    do_req(1'b0, 11'h021, '0, 4'h0, 39'h1_0000_0000);

    // Reset while the RMW read is in flight: memory must keep its old word.
    do_req(1'b1, 11'h055, 32'h01020304, 4'hF, '0);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 11'h055; req_wdata = 32'hFFFFFFFF; req_be = 4'b0011;
    @(negedge clk);
    chk("rst_test_accept", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_ram_ce", 64'(ram_ce), 64'd0);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ref_cnt = 0;
    @(negedge clk);
    chk("midrst_ready_after", 64'(req_ready), 64'd1);
    chk("midrst_corr_cnt", 64'(corr_cnt), 64'd0);
    do_req(1'b0, 11'h055, '0, 4'h0, '0);
    do_req(1'b0, 11'h055, '0, 4'h0, 39'h800);

    @(posedge clk); #1;
    s_valid = 1'b1;
    k = 0;
    repeat (14) begin
      @(negedge clk);
      if (s_rsp_valid) begin
        k++;
        chk("sat_rdata", 64'(s_rdata), 64'hCAFEF00D);
        chk("sat_err_corr", 64'(s_corr), 64'd1);
        chk("sat_corr_cnt", 64'(s_cnt), 64'((k < 3) ? k : 3));
      end
    end
    s_valid = 1'b0;
    chk("sat_rsp_count_ge4", 64'(k >= 4), 64'd1);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
    chk("wr_queue_drained", 64'(wr_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
